// File: rtl/sprite_pkg.sv
// Shared types for the per-scanline sprite evaluator: OAM entry layout, slot payload, FSM states.
package sprite_pkg;

    localparam int unsigned OAM_ENTRIES    = 64;
    localparam int unsigned OAM_ADDR_W     = 6;
    localparam logic [8:0]  OAM_DISABLED_Y = 9'h1FF;

    typedef struct packed {
        logic       flip_v;
        logic       flip_h;
        logic [2:0] palette;
        logic [7:0] tile;
        logic [8:0] y;
        logic [9:0] x;
    } oam_entry_t;

    typedef struct packed {
        logic [9:0]            x;
        logic [7:0]            tile;
        logic [3:0]            row;
        logic [2:0]            palette;
        logic                  flip_h;
        logic [OAM_ADDR_W-1:0] oam_index;
    } slot_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_DONE
    } eval_state_t;

endpackage

// File: rtl/sprite_hit_test.sv
// Combinational scanline intersection test for one OAM entry; also assembles the slot payload.
module sprite_hit_test
    import sprite_pkg::*;
#(
    parameter int unsigned SPRITE_H = 16
) (
    input  oam_entry_t                  i_entry,
    input  logic [8:0]                  i_scanline,
    input  logic [OAM_ADDR_W-1:0]       i_oam_index,
    output logic                        o_hit,
    output slot_t                       o_slot
);

    localparam logic [8:0] H_LIM   = 9'(SPRITE_H);
    localparam logic [3:0] ROW_MAX = 4'(SPRITE_H - 1);

    logic [8:0] w_diff;
    logic [3:0] w_row;

    // Modulo-512 subtraction lets sprites starting above line 0 wrap in naturally.
    assign w_diff = i_scanline - i_entry.y;
    assign w_row  = i_entry.flip_v ? (ROW_MAX - w_diff[3:0]) : w_diff[3:0];
    assign o_hit  = (w_diff < H_LIM) && (i_entry.y != OAM_DISABLED_Y);

    always_comb begin
        o_slot           = '0;
        o_slot.x         = i_entry.x;
        o_slot.tile      = i_entry.tile;
        o_slot.row       = w_row;
        o_slot.palette   = i_entry.palette;
        o_slot.flip_h    = i_entry.flip_h;
        o_slot.oam_index = i_oam_index;
    end

endmodule

// File: rtl/sprite_evaluator.sv
// Scans all 64 OAM entries for one scanline and collects the first MAX_SPRITES hits into a slot buffer.
module sprite_evaluator
    import sprite_pkg::*;
#(
    parameter int unsigned MAX_SPRITES = 8,
    parameter int unsigned SPRITE_H    = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [8:0]                     scanline,
    output logic                           busy,
    output logic                           done,
    output logic [5:0]                     oam_read_addr,
    input  logic [31:0]                    oam_read_data,
    output logic [3:0]                     sprite_count,
    output logic                           overflow,
    input  logic [$clog2(MAX_SPRITES)-1:0] slot_sel,
    output logic [9:0]                     slot_x,
    output logic [7:0]                     slot_tile,
    output logic [3:0]                     slot_row,
    output logic [2:0]                     slot_palette,
    output logic                           slot_flip_h,
    output logic [5:0]                     slot_oam_index
);

    localparam int unsigned SEL_W = $clog2(MAX_SPRITES);
    localparam int unsigned CNT_W = $clog2(MAX_SPRITES + 1);
    localparam logic [OAM_ADDR_W-1:0] LAST_ADDR = OAM_ADDR_W'(OAM_ENTRIES - 1);

    eval_state_t           r_state;
    logic                  r_busy;
    logic                  r_done;
    logic [OAM_ADDR_W-1:0] r_addr;
    logic [8:0]            r_scanline;
    logic                  r_rd_vld;
    logic [OAM_ADDR_W-1:0] r_rd_idx;
    logic [CNT_W-1:0]      r_count;
    logic                  r_overflow;
    slot_t                 r_slots [MAX_SPRITES];

    oam_entry_t            w_entry;
    logic                  w_hit;
    slot_t                 w_slot;
    slot_t                 w_rd_slot;

    assign w_entry = oam_entry_t'(oam_read_data);

    sprite_hit_test #(
        .SPRITE_H (SPRITE_H)
    ) u_hit_test (
        .i_entry     (w_entry),
        .i_scanline  (r_scanline),
        .i_oam_index (r_rd_idx),
        .o_hit       (w_hit),
        .o_slot      (w_slot)
    );

    // r_rd_vld/r_rd_idx track which address the data on oam_read_data belongs to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_addr     <= '0;
            r_scanline <= '0;
            r_rd_vld   <= 1'b0;
            r_rd_idx   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < int'(MAX_SPRITES); i++) begin
                r_slots[i] <= '0;
            end
        end else begin
            r_done   <= 1'b0;
            r_rd_vld <= 1'b0;
            r_rd_idx <= r_addr;

            if (r_rd_vld && w_hit) begin
                if (r_count < CNT_W'(MAX_SPRITES)) begin
                    r_slots[r_count[SEL_W-1:0]] <= w_slot;
                    r_count                     <= r_count + CNT_W'(1);
                end else begin
                    r_overflow <= 1'b1;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_scanline <= scanline;
                        r_count    <= '0;
                        r_overflow <= 1'b0;
                        r_addr     <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    r_rd_vld <= 1'b1;
                    if (r_addr == LAST_ADDR) begin
                        r_state <= ST_DRAIN;
                    end else begin
                        r_addr <= r_addr + OAM_ADDR_W'(1);
                    end
                end
                ST_DRAIN: begin
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign oam_read_addr = r_addr;
    assign sprite_count  = 4'(r_count);
    assign overflow      = r_overflow;

    // Unqualified read port; slots at or beyond sprite_count hold stale data.
    assign w_rd_slot      = r_slots[slot_sel];
    assign slot_x         = w_rd_slot.x;
    assign slot_tile      = w_rd_slot.tile;
    assign slot_row       = w_rd_slot.row;
    assign slot_palette   = w_rd_slot.palette;
    assign slot_flip_h    = w_rd_slot.flip_h;
    assign slot_oam_index = w_rd_slot.oam_index;

endmodule

// File: doc/sprite_evaluator.md
Name: sprite_evaluator

Overview:
Per-scanline sprite evaluation stage directly downstream of the 64-entry, 32-bit object attribute memory.
- On a start pulse it scans all 64 entries in index order and selects up to MAX_SPRITES sprites that intersect the requested scanline.
- Selected sprites go into an internal slot buffer together with the row-within-sprite, with vertical flip already applied.
- The sprite renderer reads the slot buffer during the following line. The block also flags sprite overflow.

Parameters:
MAX_SPRITES, 8, slot buffer depth (power of two, ≤ 16)
SPRITE_H, 16, sprite height in lines (power of two, ≤ 16)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle request to evaluate `scanline`
scanline  in  9  line to evaluate; sampled on the start cycle
busy  out  1  evaluation in progress
done  out  1  single-cycle pulse when the slot buffer is valid
oam_read_addr  out  6  entry index to OAM, registered
oam_read_data  in  32  OAM entry, valid one cycle after oam_read_addr changes
sprite_count  out  4  number of valid slots (0..MAX_SPRITES)
overflow  out  1  more than MAX_SPRITES sprites hit this line
slot_sel  in  $clog2(MAX_SPRITES)  slot read index (combinational read)
slot_x  out  10  x position of the selected slot
slot_tile  out  8  tile index
slot_row  out  4  row inside the sprite, flip applied
slot_palette  out  3  palette
slot_flip_h  out  1  horizontal flip
slot_oam_index  out  6  originating OAM index; lower index = higher priority

Behaviour:
- OAM entry layout (shared package):
  - [9:0] x
  - [18:10] y (9 bits)
  - [26:19] tile
  - [29:27] palette
  - [30] flip_h
  - [31] flip_v
  - y == 9'h1FF marks the entry disabled; it never hits.
- Reset values:
  - busy=0, done=0, oam_read_addr=0, sprite_count=0, overflow=0.
  - All slot fields 0; state IDLE.
- States:
  - IDLE: on start, latch scanline, clear sprite_count and overflow, set oam_read_addr=0, go to SCAN.
  - SCAN: increment oam_read_addr each cycle, 0..63. After issuing 63, go to DRAIN.
  - DRAIN: evaluate the final returned entry (index 63), then go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- busy is high in SCAN, DRAIN and DONE.
- Latency: if start is seen at edge 0, done is high in the cycle after edge 66. The total is always 66 cycles, with no early exit.
- Hit test, evaluated on each returned entry:
  - diff = (scanline − y) mod 512, 9-bit unsigned.
  - Hit if diff < SPRITE_H and the entry is not disabled.
  - Sprites above line 0 wrap naturally: y=510 with scanline=1 gives diff=3.
- Row: row = flip_v ? (SPRITE_H−1−diff) : diff, truncated to 4 bits.
- On a hit with sprite_count < MAX_SPRITES:
  - Write the slot at index sprite_count.
  - Increment sprite_count.
- On a hit with sprite_count == MAX_SPRITES: set overflow, which is sticky until the next start. No slot is written.
- The scan always covers all 64 entries, so overflow is exact.
- Slot contents and sprite_count are stable from done until the next accepted start.
- slot_sel ≥ sprite_count returns stale data; the consumer must gate on sprite_count.
- start while busy is ignored.
- The OAM index is tracked with a 1-cycle-delayed copy of oam_read_addr, so slot_oam_index matches the returned data.
- Reset mid-evaluation aborts immediately to the reset state. No done is produced.

Decomposition:
- Package sprite_pkg:
  - oam_entry_t packed struct with the layout above.
  - OAM_DISABLED_Y = 9'h1FF.
  - OAM_ENTRIES = 64.
  - slot_t struct holding x, tile, row, palette, flip_h, oam_index.
- One sub-module: sprite_hit_test, combinational. It takes the entry, scanline and SPRITE_H and returns hit and row.

Test Plan:
- Entries 0..63 all y=9'h1FF; start with scanline=100 → done exactly 66 cycles after start, sprite_count=0, overflow=0.
- Entry 5 with y=100, x=300, tile=0x42, flip_v=0 and entry 9 with y=90, flip_v=1; scanline=105 → count=2; slot0 has index 5, row 5, x 300, tile 0x42; slot1 has index 9, row 0 (diff 15, flipped).
- Ten entries with y=50, all others disabled; scanline=60 → count=8, overflow=1, slots hold OAM indices in ascending order (first eight hits).
- Entry 0 with y=510; scanline=1 → hit with row 3. Scanline=14 → no hit (diff 16).
- Reset asserted at cycle 30 of a scan → busy=0, count=0, no done pulse. A start issued after reset is released runs a full scan and gives the correct result.
- start pulsed again at cycle 10 of a busy scan → ignored; a single done arrives at cycle 66 with results for the first scanline.
